// File: rtl/adder_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adder_seq_ctrl: WIDTH-bit add computed CHUNK bits per cycle on one adder.  |
// | Optional macro ADDSEQ_SUB_EN adds a 'sub' input (two's-complement A-B).    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+

module adder #(
  parameter int CHUNK  = 16,
  parameter int CWIDTH = CHUNK/4 + CHUNK%4 + 1
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);
  localparam int NG = CHUNK / 4;
  localparam int NR = CHUNK % 4;

  // Carry chain: 4-bit groups first, leftover bits ripple singly.
  logic [CWIDTH-1:0] w_c;
  assign w_c[0] = cin;

  genvar g;
  generate
    for (g = 0; g < NG; g++) begin : g_grp
      assign {w_c[g+1], sum[4*g+3:4*g]} =
        {1'b0, a[4*g+3:4*g]} + {1'b0, b[4*g+3:4*g]} + {4'b0, w_c[g]};
    end
    for (g = 0; g < NR; g++) begin : g_bit
      assign {w_c[NG+g+1], sum[4*NG+g]} =
        {1'b0, a[4*NG+g]} + {1'b0, b[4*NG+g]} + {1'b0, w_c[NG+g]};
    end
  endgenerate

  assign cout = w_c[CWIDTH-1];
endmodule

module adder_seq_ctrl #(
  parameter int WIDTH = 106,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             busy
`ifdef ADDSEQ_SUB_EN
  ,
  input  logic             sub
`endif
);
  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PW     = NCHUNK * CHUNK;
  localparam int CWIDTH = CHUNK/4 + CHUNK%4 + 1;
  localparam int CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t r_state, w_state_next;

  logic [PW-1:0]    r_a, r_b, r_sum;
  logic             r_carry, r_cout;
  logic [CNTW-1:0]  r_cnt;
  logic [PW-1:0]    w_a_ext, w_b_ext, w_sum_next;
  logic             w_cin, w_last, w_final_cout;
  logic [CHUNK-1:0] w_chunk_sum;
  logic             w_chunk_cout;

  adder #(.CHUNK(CHUNK), .CWIDTH(CWIDTH)) u_adder (
    .a    (r_a[CHUNK-1:0]),
    .b    (r_b[CHUNK-1:0]),
    .cin  (r_carry),
    .sum  (w_chunk_sum),
    .cout (w_chunk_cout)
  );

  // Only the low WIDTH bits of B are inverted so the pad still yields the true carry.
  always_comb begin
    w_a_ext = '0;
    w_b_ext = '0;
    w_a_ext[WIDTH-1:0] = in_a;
`ifdef ADDSEQ_SUB_EN
    w_b_ext[WIDTH-1:0] = sub ? ~in_b : in_b;
    w_cin = sub ? 1'b1 : c_in;
`else
    w_b_ext[WIDTH-1:0] = in_b;
    w_cin = c_in;
`endif
  end

  always_comb begin
    w_sum_next = r_sum >> CHUNK;
    w_sum_next[PW-1 -: CHUNK] = w_chunk_sum;
  end

  assign w_last = (r_cnt == CNTW'(NCHUNK - 1));

  generate
    if (PW == WIDTH) begin : g_cout_exact
      assign w_final_cout = w_chunk_cout;
    end else begin : g_cout_pad
      logic w_unused_sum_hi;
      assign w_final_cout    = w_sum_next[WIDTH];
      assign w_unused_sum_hi = ^r_sum[PW-1:WIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_next = RUN;
      end
      RUN:  if (w_last) w_state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a     <= w_a_ext;
          r_b     <= w_b_ext;
          r_carry <= w_cin;
          r_cnt   <= '0;
        end
        RUN: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_sum   <= w_sum_next;
          r_carry <= w_chunk_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) r_cout <= w_final_cout;
        end
        default: ;
      endcase
    end
  end

  assign s     = r_sum[WIDTH-1:0];
  assign c_out = r_cout;
endmodule
`default_nettype wire

// File: tb/tb_adder_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_adder_seq_ctrl: directed vectors for the chunked sequential adder.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_adder_seq_ctrl;
  localparam int W = 106;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, c_in, out_valid, out_ready, c_out, busy;
  logic [W-1:0] in_a, in_b, s;
`ifdef ADDSEQ_SUB_EN
  logic         sub;
`endif

  logic        v53, r53, ov53, co53, b53;
  logic [52:0] a53, bb53, s53;
  logic        v16, r16, ov16, co16, b16;
  logic [15:0] a16, bb16, s16;

  int n_checks = 0;
  int n_errors = 0;
  int lat;

  adder_seq_ctrl #(.WIDTH(W), .CHUNK(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .c_in(c_in), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .c_out(c_out), .busy(busy)
`ifdef ADDSEQ_SUB_EN
    , .sub(sub)
`endif
  );

  adder_seq_ctrl #(.WIDTH(53), .CHUNK(8)) u_dut53 (
    .clk(clk), .rst(rst), .in_valid(v53), .in_ready(r53),
    .in_a(a53), .in_b(bb53), .c_in(1'b0), .out_valid(ov53),
    .out_ready(1'b1), .s(s53), .c_out(co53), .busy(b53)
`ifdef ADDSEQ_SUB_EN
    , .sub(1'b0)
`endif
  );

  adder_seq_ctrl #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16),
    .in_a(a16), .in_b(bb16), .c_in(1'b0), .out_valid(ov16),
    .out_ready(1'b1), .s(s16), .c_out(co16), .busy(b16)
`ifdef ADDSEQ_SUB_EN
    , .sub(1'b0)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sb);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    in_a = a; in_b = b; c_in = ci; in_valid = 1'b1;
`ifdef ADDSEQ_SUB_EN
    sub = sb;
`else
    if (sb) $display("note: sub ignored in add-only build");
`endif
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  // Full op with out_ready high: result checked, then handshake edge.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic sb,
                        input logic [W-1:0] exp_s, input logic exp_c);
    int n;
    out_ready = 1'b1;
    start_op(a, b, ci, sb);
    wait_valid(n);
    check({tag, "_lat"}, 128'(n), 128'(7));
    check({tag, "_s"}, 128'(s), 128'(exp_s));
    check({tag, "_cout"}, 128'(c_out), 128'(exp_c));
    tick();
  endtask

  logic [W-1:0] ones, p105;
  logic [52:0]  p52;

  initial begin
    ones = '1;
    p105 = '0; p105[105] = 1'b1;
    p52  = '0; p52[52] = 1'b1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0; c_in = 1'b0;
`ifdef ADDSEQ_SUB_EN
    sub = 1'b0;
`endif
    v53 = 1'b0; a53 = '0; bb53 = '0; v16 = 1'b0; a16 = '0; bb16 = '0;
    repeat (2) tick();
    rst = 1'b0;

    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_s", 128'(s), 128'(0));
    check("rst_cout", 128'(c_out), 128'(0));

    // 1 + 1, with handshake timing
    start_op(106'd1, 106'd1, 1'b0, 1'b0);
    check("t1_busy", 128'(busy), 128'(1));
    check("t1_in_ready_run", 128'(in_ready), 128'(0));
    wait_valid(lat);
    check("t1_lat", 128'(lat), 128'(7));
    check("t1_s", 128'(s), 128'(2));
    check("t1_cout", 128'(c_out), 128'(0));
    check("t1_in_ready_done", 128'(in_ready), 128'(0));
    tick();
    check("t1_in_ready_after", 128'(in_ready), 128'(1));
    check("t1_out_valid_after", 128'(out_valid), 128'(0));

    run_op("t2_ripple", ones, '0, 1'b1, 1'b0, '0, 1'b1);
    run_op("t2_allones", ones, ones, 1'b1, 1'b0, ones, 1'b1);
    run_op("t2_top", p105, p105, 1'b0, 1'b0, '0, 1'b1);
    run_op("t2_chunk", 106'hFFFF, 106'd1, 1'b0, 1'b0, 106'h10000, 1'b0);

    // Back-pressure
    out_ready = 1'b0;
    start_op(106'h1234, 106'h0FFF, 1'b0, 1'b0);
    wait_valid(lat);
    check("t3_lat", 128'(lat), 128'(7));
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      in_a = in_a ^ 106'h5A5A;
      tick();
      check("t3_hold_s", 128'(s), 128'(106'h2233));
      check("t3_hold_valid", 128'(out_valid), 128'(1));
      check("t3_hold_ready", 128'(in_ready), 128'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("t3_release_valid", 128'(out_valid), 128'(0));
    check("t3_release_ready", 128'(in_ready), 128'(1));
    check("t3_release_busy", 128'(busy), 128'(0));

    // Reset mid-RUN at counter 3
    start_op(ones, '0, 1'b1, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_out_valid", 128'(out_valid), 128'(0));
    check("t4_in_ready", 128'(in_ready), 128'(1));
    check("t4_s", 128'(s), 128'(0));
    check("t4_busy", 128'(busy), 128'(0));
    repeat (8) tick();
    check("t4_no_result", 128'(out_valid), 128'(0));
    run_op("t4_next", 106'd7, 106'd8, 1'b0, 1'b0, 106'd15, 1'b0);

    // Padded width: 53 bits, 8-bit chunks
    a53 = p52; bb53 = p52; v53 = 1'b1;
    tick();
    v53 = 1'b0;
    lat = 0;
    while (!ov53 && lat < 50) begin tick(); lat++; end
    check("t5_53_lat", 128'(lat), 128'(7));
    check("t5_53_s", 128'(s53), 128'(0));
    check("t5_53_cout", 128'(co53), 128'(1));
    tick();

    // Single chunk
    a16 = 16'hFFFF; bb16 = 16'h0001; v16 = 1'b1;
    tick();
    v16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 50) begin tick(); lat++; end
    check("t5_16_lat", 128'(lat), 128'(1));
    check("t5_16_s", 128'(s16), 128'(0));
    check("t5_16_cout", 128'(co16), 128'(1));
    tick();

`ifdef ADDSEQ_SUB_EN
    run_op("t6_neg", 106'd5, 106'd7, 1'b0, 1'b1, ones - 106'd1, 1'b0);
    run_op("t6_pos", 106'd7, 106'd5, 1'b1, 1'b1, 106'd2, 1'b1);
    run_op("t6_add", 106'd7, 106'd5, 1'b1, 1'b0, 106'd13, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
